// File: rtl/alu_issue_wb_if.sv
// rtl/alu_issue_wb_if.sv - issue, ALU and writeback signal bundle for alu_issue_wb
interface alu_issue_wb_if #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_sel;
    logic [RA_W-1:0]  in_dest;
    logic             in_flag_en;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             alu_c;
    logic             alu_n;
    logic             alu_z;

    logic             wb_valid;
    logic             wb_ready;
    logic [RA_W-1:0]  wb_dest;
    logic [WIDTH-1:0] wb_data;

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_dest, in_flag_en,
        output in_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_res, alu_v, alu_c, alu_n, alu_z,
        output wb_valid, wb_dest, wb_data,
        input  wb_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, in_dest, in_flag_en,
        input  in_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_res, alu_v, alu_c, alu_n, alu_z,
        input  wb_valid, wb_dest, wb_data,
        output wb_ready
    );
endinterface

// File: rtl/alu_issue_wb.sv
// rtl/alu_issue_wb.sv - issue/hold/capture sequencer around a combinational ALU with NZCV status
module alu_issue_wb #(
    parameter int          WIDTH       = 16,
    parameter int          RA_W        = 3,
    parameter int          EXEC_CYCLES = 1,
    // Reset value of the retire counter; left at zero outside bring-up.
    parameter logic [15:0] RETIRE_INIT = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    alu_issue_wb_if.slave bus,
    output logic [3:0]    status,
    output logic [15:0]   retire_count
);
    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RA_W-1:0]  dest_q;
    logic             flag_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            dest_q       <= '0;
            flag_en_q    <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.wb_valid <= 1'b0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_sel  <= '0;
            bus.wb_dest  <= '0;
            bus.wb_data  <= '0;
            status       <= 4'b0000;
            retire_count <= RETIRE_INIT;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone is the handshake.
                    if (bus.in_valid) begin
                        bus.alu_a    <= bus.in_a;
                        bus.alu_b    <= bus.in_b;
                        bus.alu_sel  <= bus.in_sel;
                        dest_q       <= bus.in_dest;
                        flag_en_q    <= bus.in_flag_en;
                        cnt          <= CNT_LOAD;
                        bus.in_ready <= 1'b0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        bus.wb_data  <= bus.alu_res;
                        bus.wb_dest  <= dest_q;
                        if (flag_en_q) begin
                            status <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
                        end
                        bus.wb_valid <= 1'b1;
                        state        <= WB;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WB: begin
                    if (bus.wb_ready) begin
                        retire_count <= retire_count + 16'd1;
                        bus.wb_valid <= 1'b0;
                        bus.in_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    bus.wb_valid <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_wb.sv
// tb/tb_alu_issue_wb.sv - directed self-checking bench for alu_issue_wb with adder-stub ALUs
module tb_alu_issue_wb;
    localparam int WIDTH = 16;
    localparam int RA_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    alu_issue_wb_if #(.WIDTH(WIDTH), .RA_W(RA_W)) b1 ();
    alu_issue_wb_if #(.WIDTH(WIDTH), .RA_W(RA_W)) b3 ();

    logic [3:0]  status1, status3;
    logic [15:0] retire1, retire3;
    logic [WIDTH-1:0] delta3 = '0;

    alu_issue_wb #(.WIDTH(WIDTH), .RA_W(RA_W), .EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .status(status1), .retire_count(retire1)
    );

    alu_issue_wb #(.WIDTH(WIDTH), .RA_W(RA_W), .EXEC_CYCLES(3), .RETIRE_INIT(16'hFFFE)) dut3 (
        .clk(clk), .rst(rst), .bus(b3), .status(status3), .retire_count(retire3)
    );

    // Adder stub ALUs; the EXEC_CYCLES=3 one adds a bench-controlled offset.
    logic [WIDTH:0] sum1, sum3;
    always_comb begin
        sum1       = {1'b0, b1.alu_a} + {1'b0, b1.alu_b};
        b1.alu_res = sum1[WIDTH-1:0];
        b1.alu_c   = sum1[WIDTH];
        b1.alu_n   = sum1[WIDTH-1];
        b1.alu_z   = (sum1[WIDTH-1:0] == '0);
        b1.alu_v   = (b1.alu_a[WIDTH-1] == b1.alu_b[WIDTH-1]) && (sum1[WIDTH-1] != b1.alu_a[WIDTH-1]);
        sum3       = {1'b0, b3.alu_a} + {1'b0, b3.alu_b} + {1'b0, delta3};
        b3.alu_res = sum3[WIDTH-1:0];
        b3.alu_c   = sum3[WIDTH];
        b3.alu_n   = sum3[WIDTH-1];
        b3.alu_z   = (sum3[WIDTH-1:0] == '0);
        b3.alu_v   = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer1(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                          input logic [2:0] dest, input logic fe);
        b1.in_a = a; b1.in_b = b; b1.in_sel = sel; b1.in_dest = dest; b1.in_flag_en = fe;
        b1.in_valid = 1'b1;
    endtask

    // Full op on the EXEC_CYCLES=1 instance with wb_ready held high.
    task automatic op1(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] dest, input logic fe,
                       input logic [15:0] exp_data, input logic [3:0] exp_status,
                       input logic [15:0] exp_retire);
        offer1(a, b, 4'd0, dest, fe);
        tick();
        b1.in_valid = 1'b0;
        check({tag, "_in_ready_exec"}, 32'(b1.in_ready), 32'd0);
        check({tag, "_wb_valid_exec"}, 32'(b1.wb_valid), 32'd0);
        check({tag, "_alu_a"}, 32'(b1.alu_a), 32'(a));
        tick();
        check({tag, "_wb_valid"}, 32'(b1.wb_valid), 32'd1);
        check({tag, "_wb_data"}, 32'(b1.wb_data), 32'(exp_data));
        check({tag, "_wb_dest"}, 32'(b1.wb_dest), 32'(dest));
        check({tag, "_status"}, 32'(status1), 32'(exp_status));
        tick();
        check({tag, "_retire"}, 32'(retire1), 32'(exp_retire));
        check({tag, "_wb_valid_done"}, 32'(b1.wb_valid), 32'd0);
        check({tag, "_in_ready_done"}, 32'(b1.in_ready), 32'd1);
    endtask

    initial begin
        b1.in_valid = 0; b1.in_a = 0; b1.in_b = 0; b1.in_sel = 0; b1.in_dest = 0; b1.in_flag_en = 0;
        b1.wb_ready = 0;
        b3.in_valid = 0; b3.in_a = 0; b3.in_b = 0; b3.in_sel = 0; b3.in_dest = 0; b3.in_flag_en = 0;
        b3.wb_ready = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready", 32'(b1.in_ready), 32'd1);
        check("rst_wb_valid", 32'(b1.wb_valid), 32'd0);
        check("rst_status", 32'(status1), 32'd0);
        check("rst_retire", 32'(retire1), 32'd0);
        check("rst_wb_data", 32'(b1.wb_data), 32'd0);
        check("rst_alu_a", 32'(b1.alu_a), 32'd0);
        check("rst_retire3", 32'(retire3), 32'hFFFE);

        b1.wb_ready = 1'b1;
        op1("add12_5", 16'd12, 16'd5, 3'd3, 1'b1, 16'd17, 4'b0000, 16'd1);
        op1("wrap_zc", 16'hFFFF, 16'd1, 3'd1, 1'b1, 16'd0, 4'b0110, 16'd2);
        op1("noflag", 16'd1, 16'd1, 3'd2, 1'b0, 16'd2, 4'b0110, 16'd3);
        op1("ovf_nv", 16'h7FFF, 16'd1, 3'd4, 1'b1, 16'h8000, 4'b1001, 16'd4);

        // Writeback stall: result held, second offer refused until retire.
        b1.wb_ready = 1'b0;
        offer1(16'd100, 16'd23, 4'd2, 3'd5, 1'b1);
        tick();
        offer1(16'd7, 16'd8, 4'd1, 3'd6, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_wb_valid", 32'(b1.wb_valid), 32'd1);
            check("stall_wb_data", 32'(b1.wb_data), 32'd123);
            check("stall_in_ready", 32'(b1.in_ready), 32'd0);
            check("stall_alu_a", 32'(b1.alu_a), 32'd100);
            tick();
        end
        check("stall_status", 32'(status1), 32'd0);
        b1.wb_ready = 1'b1;
        tick();
        check("stall_retire", 32'(retire1), 32'd5);
        check("stall_in_ready_after", 32'(b1.in_ready), 32'd1);
        tick();
        b1.in_valid = 1'b0;
        check("second_alu_a", 32'(b1.alu_a), 32'd7);
        check("second_alu_sel", 32'(b1.alu_sel), 32'd1);
        tick();
        check("second_wb_data", 32'(b1.wb_data), 32'd15);
        check("second_wb_dest", 32'(b1.wb_dest), 32'd6);
        tick();
        check("second_retire", 32'(retire1), 32'd6);

        // Reset during EXEC discards the op; status would have become 4'b1000.
        offer1(16'h8000, 16'd0, 4'd0, 3'd7, 1'b1);
        tick();
        b1.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstexec_wb_valid", 32'(b1.wb_valid), 32'd0);
        check("rstexec_status", 32'(status1), 32'd0);
        check("rstexec_retire", 32'(retire1), 32'd0);
        check("rstexec_in_ready", 32'(b1.in_ready), 32'd1);
        check("rstexec_alu_a", 32'(b1.alu_a), 32'd0);
        tick();
        check("rstexec_wb_valid_later", 32'(b1.wb_valid), 32'd0);
        op1("after_rst", 16'd2, 16'd3, 3'd1, 1'b1, 16'd5, 4'b0000, 16'd1);

        // EXEC_CYCLES=3: the ALU result seen on the third EXEC cycle is captured.
        b3.wb_ready = 1'b1;
        b3.in_a = 16'd10; b3.in_b = 16'd20; b3.in_sel = 4'd3; b3.in_dest = 3'd2; b3.in_flag_en = 1'b1;
        b3.in_valid = 1'b1;
        tick();
        b3.in_valid = 1'b0;
        delta3 = 16'd100;
        tick();
        check("ex3_wb_valid_c2", 32'(b3.wb_valid), 32'd0);
        delta3 = 16'd200;
        tick();
        check("ex3_wb_valid_c3", 32'(b3.wb_valid), 32'd0);
        delta3 = 16'd300;
        tick();
        delta3 = 16'd400;
        check("ex3_wb_valid", 32'(b3.wb_valid), 32'd1);
        check("ex3_wb_data", 32'(b3.wb_data), 32'd330);
        check("ex3_status", 32'(status3), 32'd0);
        tick();
        check("ex3_retire_ffff", 32'(retire3), 32'hFFFF);
        delta3 = 16'd0;
        b3.in_a = 16'h8000; b3.in_b = 16'h8000; b3.in_dest = 3'd4; b3.in_flag_en = 1'b1;
        b3.in_valid = 1'b1;
        tick();
        b3.in_valid = 1'b0;
        tick(); tick();
        check("ex3b_wb_valid_early", 32'(b3.wb_valid), 32'd0);
        tick();
        check("ex3b_wb_data", 32'(b3.wb_data), 32'd0);
        check("ex3b_status", 32'(status3), 32'b0110);
        tick();
        check("ex3b_retire_wrap", 32'(retire3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
